// File: rtl/sram_arbiter.sv
// sram_arbiter: three requesters (0 = CPU, 1 = video/DMA, 2 = host/debug)
// share one SRAM controller command port. The winner's command is latched
// and held for the whole controller transaction. The completion pulse is
// routed back to the winner only.
module sram_arbiter #(
  parameter bit PRIO0 = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [16:0] s0_addr,
  input  logic [31:0] s0_wrdata,
  input  logic [3:0]  s0_bytesel,
  input  logic        s0_wren,
  input  logic        s0_strobe,
  output logic        s0_wait,
  output logic [31:0] s0_rddata,

  input  logic [16:0] s1_addr,
  input  logic [31:0] s1_wrdata,
  input  logic [3:0]  s1_bytesel,
  input  logic        s1_wren,
  input  logic        s1_strobe,
  output logic        s1_wait,
  output logic [31:0] s1_rddata,

  input  logic [16:0] s2_addr,
  input  logic [31:0] s2_wrdata,
  input  logic [3:0]  s2_bytesel,
  input  logic        s2_wren,
  input  logic        s2_strobe,
  output logic        s2_wait,
  output logic [31:0] s2_rddata,

  output logic [16:0] m_addr,
  output logic [31:0] m_wrdata,
  output logic [3:0]  m_bytesel,
  output logic        m_wren,
  output logic        m_strobe,
  input  logic        m_wait,
  input  logic [31:0] m_rddata,

  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic {
    StIdle,
    StBusy
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  req;
  logic        any_req;
  logic [1:0]  winner;
  logic [1:0]  rr_n1;
  logic [1:0]  rr_n2;
  // Last grant given to port 1 or 2; drives the 1/2 rotation when port 0 has fixed priority.
  logic [1:0]  ptr12;

  assign req     = {s2_strobe, s1_strobe, s0_strobe};
  assign any_req = |req;

  // Successor in the 0 -> 1 -> 2 -> 0 rotation; index 3 never occurs.
  function automatic logic [1:0] rr_next(input logic [1:0] g);
    case (g)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  // Winner selection for the current StIdle cycle.
  always_comb begin
    rr_n1  = rr_next(grant);
    rr_n2  = rr_next(rr_n1);
    winner = grant;
    if (PRIO0) begin
      if (req[0]) begin
        winner = 2'd0;
      end else if (ptr12 == 2'd1) begin
        winner = req[2] ? 2'd2 : 2'd1;
      end else begin
        winner = req[1] ? 2'd1 : 2'd2;
      end
    end else begin
      if (req[rr_n1]) begin
        winner = rr_n1;
      end else if (req[rr_n2]) begin
        winner = rr_n2;
      end else begin
        winner = grant;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= StIdle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one grant per idle cycle, back to idle on completion.
  always_comb begin
    state_nxt = state;
    case (state)
      StIdle:  if (any_req) state_nxt = StBusy;
      StBusy:  if (!m_wait) state_nxt = StIdle;
      default: state_nxt = StIdle;
    endcase
  end

  // Command latch, grant pointers and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_addr    <= '0;
      m_wrdata  <= '0;
      m_bytesel <= '0;
      m_wren    <= 1'b0;
      m_strobe  <= 1'b0;
      grant     <= 2'd2;
      ptr12     <= 2'd2;
      busy      <= 1'b0;
    end else if (state == StIdle) begin
      if (any_req) begin
        case (winner)
          2'd0: begin
            m_addr    <= s0_addr;
            m_wrdata  <= s0_wrdata;
            m_bytesel <= s0_bytesel;
            m_wren    <= s0_wren;
          end
          2'd1: begin
            m_addr    <= s1_addr;
            m_wrdata  <= s1_wrdata;
            m_bytesel <= s1_bytesel;
            m_wren    <= s1_wren;
          end
          default: begin
            m_addr    <= s2_addr;
            m_wrdata  <= s2_wrdata;
            m_bytesel <= s2_bytesel;
            m_wren    <= s2_wren;
          end
        endcase
        m_strobe <= 1'b1;
        busy     <= 1'b1;
        grant    <= winner;
        if (winner != 2'd0) begin
          ptr12 <= winner;
        end
      end
    end else if (!m_wait) begin
      m_strobe <= 1'b0;
      busy     <= 1'b0;
    end
  end

  // Completion routing: only the granted port sees the wait pulse.
  always_comb begin
    s0_wait = !((state == StBusy) && (grant == 2'd0) && !m_wait);
    s1_wait = !((state == StBusy) && (grant == 2'd1) && !m_wait);
    s2_wait = !((state == StBusy) && (grant == 2'd2) && !m_wait);
  end

  assign s0_rddata = m_rddata;
  assign s1_rddata = m_rddata;
  assign s2_rddata = m_rddata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: a round-robin and a port-0-priority instance
// share one requester driver and one SRAM controller model; completions are
// checked against a queue of expected grants pushed as stimulus is issued.
module tb_sram_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic dut_sel;

  logic [16:0]  r_addr   [3];
  logic [31:0]  r_wdata  [3];
  logic [3:0]   r_bs     [3];
  logic         r_wren   [3];
  logic         force_low[3];
  int unsigned  issued   [3];
  int unsigned  done     [3];
  logic [2:0]   r_strobe;

  // Requester strobe: high while issued transactions are not yet completed.
  always_comb begin
    r_strobe = '0;
    for (int i = 0; i < 3; i++) begin
      r_strobe[i] = !force_low[i] && (issued[i] != done[i]);
    end
  end

  logic [2:0] stb_a, stb_b;
  logic       m_wait;
  logic [31:0] m_rddata;
  logic       mw_a, mw_b;
  assign stb_a = dut_sel ? 3'b000 : r_strobe;
  assign stb_b = dut_sel ? r_strobe : 3'b000;
  assign mw_a  = dut_sel ? 1'b1 : m_wait;
  assign mw_b  = dut_sel ? m_wait : 1'b1;

  logic [2:0]  wt_a, wt_b;
  logic [31:0] rd_a0, rd_a1, rd_a2, rd_b0, rd_b1, rd_b2;
  logic [16:0] ma_addr, mb_addr;
  logic [31:0] ma_wrdata, mb_wrdata;
  logic [3:0]  ma_bytesel, mb_bytesel;
  logic        ma_wren, mb_wren, ma_strobe, mb_strobe, ma_busy, mb_busy;
  logic [1:0]  ma_grant, mb_grant;

  sram_arbiter #(.PRIO0(1'b0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .s0_addr(r_addr[0]), .s0_wrdata(r_wdata[0]), .s0_bytesel(r_bs[0]), .s0_wren(r_wren[0]),
    .s0_strobe(stb_a[0]), .s0_wait(wt_a[0]), .s0_rddata(rd_a0),
    .s1_addr(r_addr[1]), .s1_wrdata(r_wdata[1]), .s1_bytesel(r_bs[1]), .s1_wren(r_wren[1]),
    .s1_strobe(stb_a[1]), .s1_wait(wt_a[1]), .s1_rddata(rd_a1),
    .s2_addr(r_addr[2]), .s2_wrdata(r_wdata[2]), .s2_bytesel(r_bs[2]), .s2_wren(r_wren[2]),
    .s2_strobe(stb_a[2]), .s2_wait(wt_a[2]), .s2_rddata(rd_a2),
    .m_addr(ma_addr), .m_wrdata(ma_wrdata), .m_bytesel(ma_bytesel), .m_wren(ma_wren),
    .m_strobe(ma_strobe), .m_wait(mw_a), .m_rddata(m_rddata),
    .grant(ma_grant), .busy(ma_busy)
  );

  sram_arbiter #(.PRIO0(1'b1)) u_p0 (
    .clk(clk), .reset_n(reset_n),
    .s0_addr(r_addr[0]), .s0_wrdata(r_wdata[0]), .s0_bytesel(r_bs[0]), .s0_wren(r_wren[0]),
    .s0_strobe(stb_b[0]), .s0_wait(wt_b[0]), .s0_rddata(rd_b0),
    .s1_addr(r_addr[1]), .s1_wrdata(r_wdata[1]), .s1_bytesel(r_bs[1]), .s1_wren(r_wren[1]),
    .s1_strobe(stb_b[1]), .s1_wait(wt_b[1]), .s1_rddata(rd_b1),
    .s2_addr(r_addr[2]), .s2_wrdata(r_wdata[2]), .s2_bytesel(r_bs[2]), .s2_wren(r_wren[2]),
    .s2_strobe(stb_b[2]), .s2_wait(wt_b[2]), .s2_rddata(rd_b2),
    .m_addr(mb_addr), .m_wrdata(mb_wrdata), .m_bytesel(mb_bytesel), .m_wren(mb_wren),
    .m_strobe(mb_strobe), .m_wait(mw_b), .m_rddata(m_rddata),
    .grant(mb_grant), .busy(mb_busy)
  );

  // View of whichever instance is currently selected.
  logic [2:0]  wt;
  logic [31:0] rd [3];
  logic [16:0] m_addr;
  logic [31:0] m_wrdata;
  logic [3:0]  m_bytesel;
  logic        m_wren, m_strobe, busy;
  logic [1:0]  grant;
  always_comb begin
    wt        = dut_sel ? wt_b : wt_a;
    rd[0]     = dut_sel ? rd_b0 : rd_a0;
    rd[1]     = dut_sel ? rd_b1 : rd_a1;
    rd[2]     = dut_sel ? rd_b2 : rd_a2;
    m_addr    = dut_sel ? mb_addr : ma_addr;
    m_wrdata  = dut_sel ? mb_wrdata : ma_wrdata;
    m_bytesel = dut_sel ? mb_bytesel : ma_bytesel;
    m_wren    = dut_sel ? mb_wren : ma_wren;
    m_strobe  = dut_sel ? mb_strobe : ma_strobe;
    busy      = dut_sel ? mb_busy : ma_busy;
    grant     = dut_sel ? mb_grant : ma_grant;
  end

  typedef struct {
    logic [1:0]  port;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bs;
    logic        wren;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  bit   gap_chk;

  function automatic logic [31:0] rd_pattern(input logic [16:0] a);
    if (a == 17'h00100) return 32'h11223344;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int unsigned p);
    exp_t e;
    e.port  = 2'(p);
    e.addr  = r_addr[p];
    e.wdata = r_wdata[p];
    e.bs    = r_bs[p];
    e.wren  = r_wren[p];
    e.rdata = r_wren[p] ? 32'h0 : rd_pattern(r_addr[p]);
    sb.push_back(e);
  endtask

  task automatic issue(input int unsigned p, input logic [16:0] a, input logic [31:0] wd,
                       input logic [3:0] bs, input logic wr, input bit track);
    r_addr[p]  = a;
    r_wdata[p] = wd;
    r_bs[p]    = bs;
    r_wren[p]  = wr;
    issued[p]++;
    if (track) push_exp(p);
  endtask

  // SRAM controller model: answers LAT cycles after the strobe is seen.
  task automatic model_loop();
    int unsigned cnt = 0;
    bit          active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
        m_wait = 1'b1;
      end else if (!m_wait) begin
        m_wait = 1'b1;
      end else if (active) begin
        if (cnt == 0) begin
          m_wait   = 1'b0;
          m_rddata = m_wren ? 32'h0 : rd_pattern(m_addr);
          active   = 1'b0;
        end else begin
          cnt--;
        end
      end else if (m_strobe) begin
        active = 1'b1;
        cnt    = LAT - 1;
      end
    end
  endtask

  // Completion monitor: pops the scoreboard on each wait pulse.
  task automatic monitor_loop();
    int unsigned n_low;
    int unsigned p;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n === 1'b1) begin
        n_low = 0;
        p     = 0;
        for (int i = 2; i >= 0; i--) begin
          if (wt[i] === 1'b0) begin
            n_low++;
            p = i;
          end
        end
        if (n_low != 0) begin
          chk("one_wait_low", n_low, 1);
          chk("wait_with_m_wait", m_wait, 1'b0);
          chk("completion_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_port", p, e.port);
            chk("done_grant", grant, e.port);
            chk("done_m_addr", m_addr, e.addr);
            chk("done_m_wren", m_wren, e.wren);
            if (e.wren) begin
              chk("done_m_wrdata", m_wrdata, e.wdata);
              chk("done_m_bytesel", m_bytesel, e.bs);
            end else begin
              chk("done_rddata", rd[e.port], e.rdata);
            end
          end
          done[p]++;
          gap_chk = 1'b1;
        end else if (gap_chk) begin
          chk("gap_m_strobe", m_strobe, 1'b0);
          chk("gap_busy", busy, 1'b0);
          gap_chk = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    dut_sel  = 1'b0;
    m_wait   = 1'b1;
    m_rddata = '0;
    checks   = 0;
    errors   = 0;
    gap_chk  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_bs[i] = '0; r_wren[i] = 1'b0;
      force_low[i] = 1'b0; issued[i] = 0; done[i] = 0;
    end
    fork
      model_loop();
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_strobe", m_strobe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'd2);
    chk("rst_m_addr", m_addr, 17'h0);
    chk("rst_m_wrdata", m_wrdata, 32'h0);
    chk("rst_m_bytesel", m_bytesel, 4'h0);
    chk("rst_m_wren", m_wren, 1'b0);
    chk("rst_waits", wt, 3'b111);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_m_strobe", m_strobe, 1'b0);

    // Single read from port 1
    issue(1, 17'h00100, 32'h0, 4'hF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("rd_m_strobe", m_strobe, 1'b1);
    chk("rd_m_addr", m_addr, 17'h00100);
    chk("rd_grant", grant, 2'd1);
    chk("rd_busy", busy, 1'b1);
    wait_drain(200);

    // Round-robin from reset with all ports requesting
    reset_n = 1'b0;
    issue(0, 17'h00010, 32'h0, 4'hF, 1'b0, 1'b1);
    issue(1, 17'h00011, 32'h0, 4'hF, 1'b0, 1'b1);
    issue(2, 17'h00012, 32'hA5A5_0012, 4'hF, 1'b1, 1'b1);
    issue(0, 17'h00010, 32'h0, 4'hF, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rr_first_grant", grant, 2'd0);
    wait_drain(400);

    // Port 0 fixed priority
    reset_n = 1'b0;
    dut_sel = 1'b1;
    issue(1, 17'h00020, 32'h0, 4'hF, 1'b0, 1'b1);
    issue(2, 17'h00022, 32'h0, 4'hF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("p0_first_grant", grant, 2'd1);
    chk("p0_first_busy", busy, 1'b1);
    issue(0, 17'h00030, 32'h0, 4'hF, 1'b0, 1'b1);
    push_exp(2);
    wait_drain(400);

    // Write with the requester changing its command and dropping strobe mid-transaction
    reset_n = 1'b0;
    dut_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2, 17'h1FFFF, 32'hDEADBEEF, 4'b0101, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("wr_m_addr", m_addr, 17'h1FFFF);
    chk("wr_m_wrdata", m_wrdata, 32'hDEADBEEF);
    chk("wr_m_bytesel", m_bytesel, 4'b0101);
    chk("wr_grant", grant, 2'd2);
    r_addr[2]    = 17'h0;
    r_wdata[2]   = 32'h0;
    force_low[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("wr_hold_m_addr", m_addr, 17'h1FFFF);
    chk("wr_hold_m_strobe", m_strobe, 1'b1);
    wait_drain(200);
    force_low[2] = 1'b0;

    // Reset while a transaction is outstanding
    issue(1, 17'h00040, 32'h0, 4'hF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rb_m_strobe", m_strobe, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rb_m_strobe_async", m_strobe, 1'b0);
    chk("rb_busy_async", busy, 1'b0);
    chk("rb_grant_async", grant, 2'd2);
    chk("rb_waits_async", wt, 3'b111);
    issued[1]--;
    issue(0, 17'h00050, 32'h0, 4'hF, 1'b0, 1'b1);
    issue(1, 17'h00051, 32'h0, 4'hF, 1'b0, 1'b1);
    issue(2, 17'h00052, 32'h0, 4'hF, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rb_first_grant", grant, 2'd0);
    wait_drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Three-port arbiter that shares the single 32-bit command interface of the SRAM controller between requesters: port 0 = CPU, port 1 = video/DMA fetch, port 2 = host/debug loader. It sits between the requesters and the SRAM controller. It latches the winning command, holds it stable for the whole controller transaction, and routes the one-cycle completion pulse back to the winner only.

## Interface
- `PRIO0`, default 0: 0 = round-robin over all three ports; 1 = port 0 fixed highest priority, ports 1/2 round-robin between themselves.
- `clk  in  1`: single clock; all logic on rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `s0_addr`/`s1_addr`/`s2_addr  in  17`: requester longword address.
- `s0_wrdata`/`s1_wrdata`/`s2_wrdata  in  32`: requester write data.
- `s0_bytesel`/`s1_bytesel`/`s2_bytesel  in  4`: requester byte enables (write only).
- `s0_wren`/`s1_wren`/`s2_wren  in  1`: 1 = write, 0 = read.
- `s0_strobe`/`s1_strobe`/`s2_strobe  in  1`: request; held high until that port's wait goes low.
- `s0_wait`/`s1_wait`/`s2_wait  out  1`: low for exactly one cycle when that port's transaction completes.
- `s0_rddata`/`s1_rddata`/`s2_rddata  out  32`: read data; valid in the cycle the port's wait is low.
- `m_addr  out  17`: latched command to the SRAM controller.
- `m_wrdata  out  32`: latched command to the SRAM controller.
- `m_bytesel  out  4`: latched command to the SRAM controller.
- `m_wren  out  1`: latched command to the SRAM controller.
- `m_strobe  out  1`: latched command to the SRAM controller.
- `m_wait  in  1`: controller completion; low for one cycle at transaction end.
- `m_rddata  in  32`: controller read data (registered by the controller).
- `grant  out  2`: index of the last or current granted port.
- `busy  out  1`: 1 while a transaction is outstanding.

## Operation
- **States:**
  - StIdle: `m_strobe` = 0; arbitrates.
  - StBusy: `m_strobe` = 1; waits for completion.
- **StIdle:**
  - If any `sN_strobe` = 1, select the winner and register the winner's addr/wrdata/bytesel/wren into the `m_*` registers.
  - Set `m_strobe` <= 1, `grant` <= winner, `busy` <= 1, go to StBusy.
  - If no request is pending, stay in StIdle with all registers unchanged.
- **Round-robin:** pointer = `grant`. Search order is `grant`+1, `grant`+2, `grant` (mod 3; index 3 never occurs). The winner becomes the new pointer.
- **PRIO0=1:** port 0 wins whenever requesting. Otherwise the search is over ports 1/2 only, starting after the last 1/2 grant (tracked separately).
- **StBusy:**
  - `m_*` are held constant regardless of requester inputs.
  - When `m_wait` = 0: `m_strobe` <= 0, `busy` <= 0, go to StIdle.
- **Wait routing (combinational):** `sN_wait` = !(state==StBusy && `grant`==N && !`m_wait`). All other ports read 1.
- **Read data:** `sN_rddata` = `m_rddata` for all ports; only meaningful with that port's wait low.
- **Strobe dropped or command changed mid-transaction (protocol violation):**
  - The latched command still completes.
  - The wait pulse still goes to the granted port.
  - No abort.
- **Reset (any time, including StBusy):**
  - state = StIdle; `m_strobe`/`m_wren` = 0; `m_addr`/`m_wrdata`/`m_bytesel` = 0.
  - `grant` = 2, so port 0 is first under round-robin; the PRIO0 1/2 pointer = 2.
  - `busy` = 0; all `sN_wait` = 1.
  - The controller shares the system reset, so no transaction resumes.

## Timing
- **Grant latency:** request seen in StIdle at cycle t gives `m_strobe`=1 with the latched command from cycle t+1.
- **Completion:** `sN_wait` low in the same cycle `m_wait` is low; there is no added latency.
- **Gap:** after completion, `m_strobe` is 0 for exactly one cycle (StIdle). This matches the controller re-arming its idle state, so there is never a spurious restart.
- **Throughput:** one controller transaction plus one idle cycle per grant.
- **Re-request:** a port may keep strobe high in the cycle after its wait pulse. That is a new request and competes normally in StIdle.
- **Simultaneous requests:** all arrive in the same StIdle cycle, so exactly one grant per StIdle cycle.

## Test plan
- **Single read:** PRIO0=0; `s1_strobe`=1, `s1_addr`=0x00100, wren=0 -> `m_strobe`=1 next cycle with `m_addr`=0x00100. When the model returns 0x11223344 with `m_wait` low, `s1_wait` is low one cycle with `s1_rddata`=0x11223344; `s0_wait`/`s2_wait` stay 1.
- **Round-robin from reset:** all three strobes held from reset -> grant order 0,1,2,0. Each grant has one `m_strobe`-low cycle between completions.
- **PRIO0=1:** ports 1 and 2 pending; port 0 asserts during port 1's transaction -> next grant is 0, then 2.
- **Write with requester misbehaviour:** `s2` writes 0xDEADBEEF, bytesel 4'b0101, addr 0x1FFFF. `s2_addr` changes to 0 and strobe drops mid-transaction -> `m_addr` stays 0x1FFFF and the wait pulse still goes to port 2.
- **Reset during StBusy:** assert `reset_n`=0 in StBusy -> `m_strobe`=0 immediately (async) and all waits = 1. After release with all ports requesting, the first grant is port 0.
